// File: rtl/nexys4_btn_debounce.sv
// Six-channel button synchronizer/debouncer feeding the KCPSM6 db_btns input.
// Define DB_PRESS_PULSE_EN to enable the registered one-cycle db_press pulses.
module nexys4_btn_debounce #(
  parameter int unsigned DB_CYCLES   = 500_000,
  parameter int unsigned CNT_W       = 20,
  parameter logic [5:0]  INVERT_MASK = 6'b000001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] pbtn_raw,
  output logic [5:0] db_btns,
  output logic [5:0] db_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } st_e;

  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       sync1_d;
  logic [5:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  st_e              st    [6];

  assign sync1_d = pbtn_raw ^ INVERT_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // State is implied by db vs sync2; cnt is 0 whenever STABLE.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      st[i] = (sync2_q[i] != db_q[i]) ? PENDING : STABLE;
    end
  end

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      unique case (st[i])
        STABLE: cnt_d[i] = '0;
        PENDING: begin
          if (cnt_q[i] == CNT_LAST) begin
            db_d[i] = ~db_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign db_btns = db_q;

`ifdef DB_PRESS_PULSE_EN
  logic [5:0] press_q, press_d;

  always_comb begin
    press_d = db_d & ~db_q;
  end

  always_ff @(posedge clk) begin
    if (reset) press_q <= '0;
    else       press_q <= press_d;
  end

  assign db_press = press_q;
`else
  assign db_press = 6'b0;
`endif

endmodule

// File: tb/tb_nexys4_btn_debounce.sv
// Directed scoreboard bench for nexys4_btn_debounce (DB_CYCLES=8, CNT_W=4).
// Press-pulse expectations follow DB_PRESS_PULSE_EN.
module tb_nexys4_btn_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] pbtn_raw;
  logic [5:0] db_btns;
  logic [5:0] db_press;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string      tag;
    int         due;
    logic [5:0] db;
    logic [5:0] pr;
  } exp_t;

  exp_t q[$];

  nexys4_btn_debounce #(
    .DB_CYCLES  (8),
    .CNT_W      (4),
    .INVERT_MASK(6'b000001)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pbtn_raw(pbtn_raw),
    .db_btns (db_btns),
    .db_press(db_press)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pex(input logic [5:0] p);
`ifdef DB_PRESS_PULSE_EN
    return p;
`else
    return 6'b0;
`endif
  endfunction

  // n = edges after edge k (the first edge after this drive).
  task automatic expect_at(input string tag, input int n,
                           input logic [5:0] db, input logic [5:0] pr);
    exp_t e;
    e.tag = tag;
    e.due = cyc + n + 1;
    e.db  = db;
    e.pr  = pr;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      assert (db_btns === e.db && db_press === e.pr && e.due == cyc)
      else begin
        errors++;
        $error("FAIL %s: db_btns=%b db_press=%b expected %b %b",
               e.tag, db_btns, db_press, e.db, e.pr);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset    = 1'b1;
    pbtn_raw = 6'b111110;

    // reset held with all buttons pressed
    for (int n = 0; n < 3; n++) expect_at("rst_hold", n, 6'h00, 6'h00);
    run(3);
    reset = 1'b0;
    expect_at("rst_rel_early", 8, 6'h00, 6'h00);
    expect_at("rst_rel_rise", 9, 6'h3f, pex(6'h3f));
    expect_at("rst_rel_after", 10, 6'h3f, 6'h00);
    run(11);

    // go idle
    pbtn_raw = 6'b000001;
    expect_at("idle_early", 8, 6'h3f, 6'h00);
    expect_at("idle_fall", 9, 6'h00, 6'h00);
    expect_at("idle_after", 10, 6'h00, 6'h00);
    run(11);

    // clean press on bit 5
    pbtn_raw = 6'b100001;
    expect_at("press_early", 8, 6'h00, 6'h00);
    expect_at("press_rise", 9, 6'h20, pex(6'h20));
    expect_at("press_one", 10, 6'h20, 6'h00);
    run(11);
    pbtn_raw = 6'b000001;
    expect_at("press_rel_early", 8, 6'h20, 6'h00);
    expect_at("press_rel", 9, 6'h00, 6'h00);
    run(10);

    // bounce on bit 3
    pbtn_raw = 6'b001001;
    for (int n = 0; n < 5; n++) expect_at("bounce_hi", n, 6'h00, 6'h00);
    run(5);
    pbtn_raw = 6'b000001;
    for (int n = 0; n < 2; n++) expect_at("bounce_lo", n, 6'h00, 6'h00);
    run(2);
    pbtn_raw = 6'b001001;
    for (int n = 0; n < 9; n++) expect_at("bounce_hold", n, 6'h00, 6'h00);
    expect_at("bounce_rise", 9, 6'h08, pex(6'h08));
    expect_at("bounce_after", 10, 6'h08, 6'h00);
    run(11);
    pbtn_raw = 6'b000001;
    expect_at("bounce_rel", 9, 6'h00, 6'h00);
    run(10);

    // 7-cycle glitch on bit 2
    pbtn_raw = 6'b000101;
    for (int n = 0; n < 7; n++) expect_at("glitch_hi", n, 6'h00, 6'h00);
    run(7);
    pbtn_raw = 6'b000001;
    for (int n = 0; n < 13; n++) expect_at("glitch_lo", n, 6'h00, 6'h00);
    run(13);

    // bits 4 and 1 pressed, then released together
    pbtn_raw = 6'b010011;
    expect_at("simul_rise", 9, 6'h12, pex(6'h12));
    run(10);
    pbtn_raw = 6'b000001;
    expect_at("simul_rel_early", 8, 6'h12, 6'h00);
    expect_at("simul_rel", 9, 6'h00, 6'h00);
    expect_at("simul_rel_after", 10, 6'h00, 6'h00);
    run(11);

    // cpu_reset button is active low
    pbtn_raw = 6'b000000;
    expect_at("cpurst_early", 8, 6'h00, 6'h00);
    expect_at("cpurst_rise", 9, 6'h01, pex(6'h01));
    expect_at("cpurst_after", 10, 6'h01, 6'h00);
    run(11);
    pbtn_raw = 6'b000001;
    expect_at("cpurst_rel", 9, 6'h00, 6'h00);
    run(10);

    // reset mid-count on bit 5
    pbtn_raw = 6'b100001;
    expect_at("mid_pend", 3, 6'h00, 6'h00);
    run(4);
    reset = 1'b1;
    expect_at("mid_rst", 0, 6'h00, 6'h00);
    expect_at("mid_rst", 1, 6'h00, 6'h00);
    run(2);
    reset = 1'b0;
    expect_at("mid_early", 8, 6'h00, 6'h00);
    expect_at("mid_rise", 9, 6'h20, pex(6'h20));
    expect_at("mid_after", 10, 6'h20, 6'h00);
    run(11);

    while (q.size() > 0) begin
      void'(q.pop_front());
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nexys4_btn_debounce.md
# nexys4_btn_debounce

Six-channel pushbutton synchronizer and debouncer for the Nexys4 board buttons. Sits directly upstream of the KCPSM6 I/O interface and drives its `db_btns[5:0]` input with clean, glitch-free, active-high levels. It may also produce one-cycle press pulses (see Configuration). Each channel is independent, with its own synchronizer, stability counter and two-state debounce FSM.

## Interface
- `DB_CYCLES`, 500_000: consecutive stable cycles required before an output changes. This is 5 ms at 100 MHz. Legal range is 2 .. 2^CNT_W−1.
- `CNT_W`, 20: stability counter width. Must satisfy 2^CNT_W > DB_CYCLES.
- `INVERT_MASK`, 6'b000001: per-bit raw-input inversion applied before synchronization. Bit 0 is the active-low CPU_RESET button.

- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: synchronous, active-high.
- `pbtn_raw`  in  6: raw board buttons, asynchronous. Bit order is {center, left, up, right, down, cpu_reset}.
- `db_btns`  out  6: debounced levels, same bit order, 1 = pressed. Feeds the KCPSM6 interface.
- `db_press`  out  6: one-cycle press pulses. Tied to 0 unless `DB_PRESS_PULSE_EN` is defined.

## Operation
- Input stage: `pin[i] = pbtn_raw[i] ^ INVERT_MASK[i]`, then two flops, `sync1` → `sync2`. Only `sync2` is used downstream.
- Per-channel FSM:
  - States are STABLE (`sync2 == db_btns[i]`) and PENDING (`sync2 != db_btns[i]`). State is held as `db_btns[i]` plus `cnt[i]`.
  - **STABLE**: `cnt` is held at 0. If `sync2 != db_btns[i]`, go to PENDING and set `cnt` to 1.
  - **PENDING, mismatch persists**: if `cnt == DB_CYCLES−1`, toggle `db_btns[i]`, clear `cnt` and return to STABLE. Otherwise increment `cnt`.
  - **PENDING, sync2 returns to db_btns[i]** (bounce): clear `cnt` and return to STABLE. The output does not change.
- `cnt` saturation/wrap is unreachable by construction because of the DB_CYCLES bound.
- Channels never interact. Simultaneous transitions on any subset of channels are handled independently, with identical latency.
- Reset: `sync1`, `sync2`, `cnt`, `db_btns` and `db_press` are all cleared to 0. Reset asserted mid-count abandons the pending transition. After release, a held button re-qualifies from zero and needs the full latency again.

## Timing
- All outputs are registered. Reset values: `db_btns = 6'b0`, `db_press = 6'b0`.
- Latency: edge k is the first edge at which `sync1` samples the new level. If the level is held, `db_btns[i]` changes at edge k+1+DB_CYCLES and is visible after that edge.
- Minimum accepted pulse width: DB_CYCLES clocks at `sync2`. Any shorter excursion produces no output change.
- A bounce at any point during PENDING restarts qualification. The full DB_CYCLES count is needed after the last bounce.
- A release is qualified symmetrically, with the same latency.
- `db_press[i]` asserts for exactly one cycle, on the same edge that `db_btns[i]` goes 0→1. There is no pulse on 1→0.

## Configuration
- Macro: `DB_PRESS_PULSE_EN`.
- **Defined**: `db_press` is driven as above, by a registered rising-edge detect aligned with the `db_btns` rise. Adds six flops.
- **Undefined**: `db_press` is a constant 6'b0 and no edge-detect logic is generated. `db_btns` behaviour is identical in both builds.

## Test plan
Bench uses DB_CYCLES=8, CNT_W=4, `DB_PRESS_PULSE_EN` defined, and `pbtn_raw` idle at 6'b000001 (all released after inversion).
- **Reset**: drive `reset`=1 for 3 cycles with `pbtn_raw`=6'b111110 → `db_btns`=0 and `db_press`=0 throughout. After release, `db_btns` reaches 6'b111111 at edge k+9.
- **Clean press**: raise bit 5 at edge k and hold → `db_btns`=6'b100000 exactly after edge k+9. `db_press[5]`=1 for that single cycle only.
- **Bounce**: on bit 3, apply high for 5 cycles, low for 2, then high and held → no output change during the bounce. `db_btns[3]` rises 9 edges after the final rising sample.
- **Short glitch**: raise bit 2 for 7 cycles, then return low → `db_btns` and `db_press` stay 0.
- **Release and simultaneity**: with bits 4 and 1 held, release both on the same edge → both clear together 9 edges later, with no `db_press` pulse. Separately, drive `pbtn_raw[0]`=0 → `db_btns[0]`=1.
- **Reset mid-count**: assert `reset` 4 cycles into a PENDING press on bit 5, then release with the button still held → `db_btns[5]` rises 9 edges after reset deasserts, not earlier.
